// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0064;
    localparam int          DEPTH_DEF    = 2;
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, inst} pairs; flush wins over push and pop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [31:0]                head_pc,
    output logic [31:0]                head_inst
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   inst_mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0;
                inst_mem_r[i] <= 32'h0;
            end
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                pc_mem_r[wr_ptr_r]   <= in_pc;
                inst_mem_r[wr_ptr_r] <= in_inst;
                wr_ptr_r             <= next_ptr(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != '0);
    assign head_pc    = head_valid ? pc_mem_r[rd_ptr_r]   : 32'h0;
    assign head_inst  = head_valid ? inst_mem_r[rd_ptr_r] : 32'h0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues single-outstanding imem requests,
// buffers returned instructions for decode and handles branch redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_r, state_n_s;
    logic [31:0]   pc_r, pc_adv_s, pc_n_s, tgt_s;
    logic          inflight_r, infl_n_s;
    logic [31:0]   infl_pc_r, infl_pc_n_s;
    logic          drop_r, drop_n_s;
    logic          req_r, req_n_s;
    logic [31:0]   addr_r;
    logic [CW-1:0] count_s, count_n_s;
    logic          gnt_fire_s, rv_s, push_s, pop_s, credit_s;

    assign gnt_fire_s = req_r & imem_gnt;
    assign rv_s       = imem_rvalid & inflight_r;
    assign push_s     = rv_s & ~drop_r & ~redirect_valid;
    assign pop_s      = if_valid & if_ready;
    assign tgt_s      = word_align(redirect_pc);

    fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .in_pc      (infl_pc_r),
        .in_inst    (imem_rdata),
        .count      (count_s),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_inst  (if_inst)
    );

    // Occupancy the buffer will have after this edge, used for the credit check.
    always_comb begin
        count_n_s = count_s;
        if (redirect_valid) begin
            count_n_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_n_s = count_s + CW'(1);
                2'b01:   count_n_s = count_s - CW'(1);
                default: count_n_s = count_s;
            endcase
        end
    end

    // Next-state logic for the sequencer and its transaction bookkeeping.
    always_comb begin
        state_n_s   = state_r;
        pc_adv_s    = pc_r;
        infl_n_s    = inflight_r;
        infl_pc_n_s = infl_pc_r;
        drop_n_s    = drop_r;
        case (state_r)
            S_BOOT: begin
                state_n_s = S_REQ;
            end
            S_REQ: begin
                if (gnt_fire_s) begin
                    infl_n_s    = 1'b1;
                    infl_pc_n_s = pc_r;
                    pc_adv_s    = pc_r + 32'd4;
                    drop_n_s    = redirect_valid;
                    state_n_s   = S_WAIT;
                end else begin
                    state_n_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (rv_s) begin
                    infl_n_s  = 1'b0;
                    drop_n_s  = 1'b0;
                    state_n_s = S_REQ;
                end else if (redirect_valid) begin
                    drop_n_s = 1'b1;
                end else begin
                    drop_n_s = drop_r;
                end
            end
            default: begin
                state_n_s = S_BOOT;
            end
        endcase
    end

    // A redirect always overrides the sequential advance, even on a grant.
    assign pc_n_s   = redirect_valid ? tgt_s : pc_adv_s;
    assign credit_s = (32'(count_n_s) + 32'(infl_n_s)) < 32'(DEPTH);
    assign req_n_s  = (state_n_s == S_REQ) && credit_s;

    // Sequencer state and registered imem request outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= S_BOOT;
            pc_r       <= RESET_PC;
            inflight_r <= 1'b0;
            infl_pc_r  <= 32'h0;
            drop_r     <= 1'b0;
            req_r      <= 1'b0;
            addr_r     <= word_align(RESET_PC);
        end else begin
            state_r    <= state_n_s;
            pc_r       <= pc_n_s;
            inflight_r <= infl_n_s;
            infl_pc_r  <= infl_pc_n_s;
            drop_r     <= drop_n_s;
            req_r      <= req_n_s;
            addr_r     <= word_align(pc_n_s);
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: queue-based reference model plus literal sequence checks.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0064;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // bench knobs
    logic gnt_en = 1'b0;
    logic rdy = 1'b0;
    logic extra_rv = 1'b0;
    int   lat = 1;

    // memory responder
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    // reference model
    ent_t        mbuf[$];
    logic        m_boot = 1'b1;
    logic [31:0] m_pc = RST_PC;
    logic        m_pend = 1'b0;
    logic [31:0] pend_pc = 32'h0;
    logic        pend_drop = 1'b0;

    logic [31:0] seen[$];
    logic [31:0] gaddr[$];

    fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input bit grants, input int i);
        if (grants) begin
            return (i < gaddr.size()) ? gaddr[i] : 32'hFFFF_FFFF;
        end else begin
            return (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF;
        end
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic redir, input logic [31:0] rpc);
        logic        e_req, e_valid, rv;
        logic [31:0] e_addr, e_pc, e_inst, rd;
        ent_t        e;
        e_req   = !m_boot && !m_pend && (mbuf.size() < DEPTH);
        e_addr  = {m_pc[31:2], 2'b00};
        e_valid = (mbuf.size() > 0);
        e_pc    = e_valid ? mbuf[0].pc : 32'h0;
        e_inst  = e_valid ? mbuf[0].inst : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, e_addr);
        chk("if_valid", 32'(if_valid), 32'(e_valid));
        chk("if_pc", if_pc, e_pc);
        chk("if_inst", if_inst, e_inst);

        rv = (mem_busy && mem_cnt == 0) || extra_rv;
        rd = extra_rv ? 32'hDEAD_BEEF : (rv ? mem_data(mem_addr) : 32'h0);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = gnt_en;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        if_ready       = rdy;

        if (if_valid && rdy) seen.push_back(if_pc);
        if (imem_req && gnt_en) gaddr.push_back(imem_addr);

        if (rv && !extra_rv) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (imem_req && gnt_en) begin
            mem_busy = 1'b1;
            mem_cnt  = lat - 1;
            mem_addr = imem_addr;
        end

        if (e_valid && rdy) void'(mbuf.pop_front());
        if (m_pend && rv) begin
            if (!pend_drop && !redir) begin
                e.pc   = pend_pc;
                e.inst = rd;
                mbuf.push_back(e);
            end
            m_pend = 1'b0;
        end else if (e_req && gnt_en) begin
            m_pend    = 1'b1;
            pend_pc   = m_pc;
            pend_drop = redir;
            m_pc      = m_pc + 32'd4;
        end
        if (m_pend && redir) pend_drop = 1'b1;
        if (redir) begin
            mbuf.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end
        m_boot = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic do_reset(input bit clr_mem);
        rstn = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        if_ready = 1'b0;
        extra_rv = 1'b0;
        mbuf.delete();
        m_boot = 1'b1;
        m_pc = RST_PC;
        m_pend = 1'b0;
        pend_drop = 1'b0;
        if (clr_mem) mem_busy = 1'b0;
        seen.delete();
        gaddr.delete();
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        @(negedge clk);

        // 1: streaming at full rate
        gnt_en = 1'b1; rdy = 1'b1; lat = 1;
        do_reset(1'b1);
        chk("t1_boot_req", 32'(imem_req), 32'h0);
        run(10);
        chk("t1_g0", q_at(1'b1, 0), 32'h64);
        chk("t1_g1", q_at(1'b1, 1), 32'h68);
        chk("t1_g2", q_at(1'b1, 2), 32'h6C);
        chk("t1_s0", q_at(1'b0, 0), 32'h64);
        chk("t1_s1", q_at(1'b0, 1), 32'h68);
        chk("t1_s2", q_at(1'b0, 2), 32'h6C);

        // 2: decode stalled, buffer fills, then drains
        gnt_en = 1'b1; rdy = 1'b0; lat = 1;
        do_reset(1'b1);
        run(10);
        chk("t2_full_req", 32'(imem_req), 32'h0);
        chk("t2_head", if_pc, 32'h64);
        chk("t2_ngrant", 32'(gaddr.size()), 32'd2);
        rdy = 1'b1;
        run(8);
        chk("t2_s0", q_at(1'b0, 0), 32'h64);
        chk("t2_s1", q_at(1'b0, 1), 32'h68);
        chk("t2_g2", q_at(1'b1, 2), 32'h6C);

        // 3: grant withheld for three cycles
        gnt_en = 1'b0; rdy = 1'b1; lat = 1;
        do_reset(1'b1);
        run(4);
        chk("t3_req_hold", 32'(imem_req), 32'h1);
        chk("t3_addr_hold", imem_addr, 32'h64);
        chk("t3_nogrant", 32'(gaddr.size()), 32'd0);
        gnt_en = 1'b1;
        run(1);
        gnt_en = 1'b0;
        run(3);
        chk("t3_one_grant", 32'(gaddr.size()), 32'd1);
        chk("t3_g0", q_at(1'b1, 0), 32'h64);

        // 4: redirect while the 0x68 response is outstanding
        gnt_en = 1'b1; rdy = 1'b1; lat = 3;
        do_reset(1'b1);
        n = 0;
        while (!(m_pend && pend_pc == 32'h68) && n < 50) begin
            run(1);
            n++;
        end
        chk("t4_reach", 32'(n < 50), 32'h1);
        cycle(1'b1, 32'h1003);
        run(16);
        chk("t4_g1", q_at(1'b1, 1), 32'h68);
        chk("t4_g2", q_at(1'b1, 2), 32'h1000);
        chk("t4_s0", q_at(1'b0, 0), 32'h64);
        chk("t4_s1", q_at(1'b0, 1), 32'h1000);

        // 5: redirect together with rvalid, then redirect together with grant
        gnt_en = 1'b1; rdy = 1'b1; lat = 1;
        do_reset(1'b1);
        n = 0;
        while (!(m_pend && pend_pc == 32'h68) && n < 50) begin
            run(1);
            n++;
        end
        chk("t5_reach", 32'(n < 50), 32'h1);
        cycle(1'b1, 32'h2000);
        chk("t5_req", 32'(imem_req), 32'h1);
        chk("t5_addr", imem_addr, 32'h2000);
        n = 0;
        while (!(!m_pend && mbuf.size() < DEPTH && m_pc == 32'h2004) && n < 50) begin
            run(1);
            n++;
        end
        chk("t5_reach2", 32'(n < 50), 32'h1);
        cycle(1'b1, 32'h3000);
        run(10);
        chk("t5_g3", q_at(1'b1, 3), 32'h2004);
        chk("t5_g4", q_at(1'b1, 4), 32'h3000);
        chk("t5_s1", q_at(1'b0, 1), 32'h2000);
        chk("t5_s2", q_at(1'b0, 2), 32'h3000);

        // 6: reset while a request is in flight, late rvalid ignored
        gnt_en = 1'b1; rdy = 1'b1; lat = 10;
        do_reset(1'b1);
        run(3);
        chk("t6_pending", 32'(m_pend), 32'h1);
        do_reset(1'b1);
        gnt_en = 1'b0; extra_rv = 1'b1;
        run(2);
        extra_rv = 1'b0;
        chk("t6_valid", 32'(if_valid), 32'h0);
        gnt_en = 1'b1; lat = 1;
        run(8);
        chk("t6_g0", q_at(1'b1, 0), 32'h64);
        chk("t6_s0", q_at(1'b0, 0), 32'h64);

        // redirect during the boot cycle keeps the idle cycle
        do_reset(1'b1);
        cycle(1'b1, 32'h4002);
        chk("boot_redir_req", 32'(imem_req), 32'h1);
        chk("boot_redir_addr", imem_addr, 32'h4000);
        run(6);
        chk("boot_redir_s0", q_at(1'b0, 0), 32'h4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
